// File: rtl/loader_pkg.sv
// loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_e : loader FSM states
//   LEN_W          : width of the word-count field at the head of a frame
//   BYTE_W/WORD_W  : stream byte and instruction word widths
//   LAST_LANE      : byte index of the final (least significant) byte of a word
//   laneLsb()      : bit position of byte lane 0..3 inside a big-endian word
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_e;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;

    localparam logic [1:0] LAST_LANE = 2'd3;

    // Lane 0 is the most significant byte, so lanes map to
    // bits [31:24], [23:16], [15:8], [7:0] in that order.
    function automatic int laneLsb(input logic [1:0] idx);
        return WORD_W - BYTE_W * (int'(idx) + 1);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// byte_packer
// Assembles four stream bytes, most significant first, into a 32-bit word.
//   clk, rst   : clock and asynchronous active-high reset
//   clear_i    : restart packing at byte index 0
//   accept_i   : a byte is transferred this cycle
//   byte_i     : the byte being transferred
//   word_o     : the word as it would look with byte_i placed in the current lane
//   last_o     : the current lane is the final byte of a word
module byte_packer
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              accept_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              last_o
);

    logic [1:0]        idx_q;
    logic [WORD_W-1:0] word_q;

    // Byte index and partially assembled word; the index wraps naturally
    // after the fourth byte so the next word starts in lane 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            idx_q  <= '0;
            word_q <= '0;
        end else if (accept_i) begin
            word_q[laneLsb(idx_q) +: BYTE_W] <= byte_i;
            idx_q                            <= idx_q + 2'd1;
        end
    end

    // The complete word is presented combinationally during the fourth byte
    // so the top level can register it on the same edge that consumes it.
    always_comb begin
        word_o                            = word_q;
        word_o[laneLsb(idx_q) +: BYTE_W]  = byte_i;
        last_o                            = (idx_q == LAST_LANE);
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads a framed, checksummed byte stream into instruction memory and holds
// the processor in reset until a complete, verified image is present.
// Frame: LEN_HI, LEN_LO (word count N), 4*N data bytes, CSUM (XOR of all
// preceding frame bytes).
//   clk, rst  : clock and asynchronous active-high reset
//   start     : begin a load (honoured in IDLE, DONE, ERR)
//   in_data   : stream byte, transferred when in_valid && in_ready
//   in_valid  : stream byte valid
//   in_ready  : loader can accept a byte
//   wr_en     : one-cycle instruction memory write strobe
//   wr_addr   : word address of the write
//   wr_data   : instruction word
//   cpu_rst   : processor reset, low only once an image is verified
//   done      : image loaded and checksum matched
//   error     : checksum mismatch or length larger than the memory
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              cpu_rst,
    output logic              done,
    output logic              error
);

    // One extra bit so a full-memory image (N == 2^ADDR_W) is representable.
    localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(1) << ADDR_W;

    loader_state_e state_q, state_d;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wordCnt_q, wordCnt_d;
    logic [BYTE_W-1:0] xor_q, xor_d;

    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_W-1:0] wr_data_q, wr_data_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              xfer;
    logic              enterLenHi;
    logic              packAccept;
    logic              packLast;
    logic [WORD_W-1:0] packWord;
    logic [LEN_W:0]    lenFull;
    logic              lastWord;

    assign xfer       = in_valid && in_ready_q;
    assign packAccept = (state_q == DATA) && xfer;
    assign enterLenHi = (state_d == LEN_HI) && (state_q != LEN_HI);
    assign lenFull    = {1'b0, len_q[LEN_W-1:BYTE_W], in_data};
    assign lastWord   = (wordCnt_q == (len_q - LEN_W'(1)));

    byte_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (enterLenHi),
        .accept_i (packAccept),
        .byte_i   (in_data),
        .word_o   (packWord),
        .last_o   (packLast)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. An oversized length aborts straight to ERR
    // without consuming the checksum byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = LEN_HI;
            end
            LEN_HI: begin
                if (xfer) state_d = LEN_LO;
            end
            LEN_LO: begin
                if (xfer) begin
                    if (lenFull > CAPACITY)  state_d = ERR;
                    else if (lenFull == '0)  state_d = CSUM;
                    else                     state_d = DATA;
                end
            end
            DATA: begin
                if (packAccept && packLast && lastWord) state_d = CSUM;
            end
            CSUM: begin
                if (xfer) state_d = (in_data == xor_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next-state logic. Status outputs follow the state being entered
    // so they change in the same cycle the new state becomes visible.
    always_comb begin
        in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                     (state_d == DATA)   || (state_d == CSUM);
        cpu_rst_d  = (state_d != DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERR);
        wr_en_d    = packAccept && packLast;
        wr_data_d  = wr_en_d ? packWord : wr_data_q;
        wr_addr_d  = wr_addr_q;
        if (enterLenHi) begin
            wr_addr_d = '0;
        end else if (wr_en_q) begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end
    end

    // Datapath next-state: length capture, word count and running checksum.
    always_comb begin
        len_d     = len_q;
        wordCnt_d = wordCnt_q;
        xor_d     = xor_q;
        if (enterLenHi) begin
            wordCnt_d = '0;
            xor_d     = '0;
        end else begin
            if (xfer && (state_q != CSUM)) xor_d = xor_q ^ in_data;
            if (xfer && (state_q == LEN_HI)) len_d = {in_data, len_q[BYTE_W-1:0]};
            if (xfer && (state_q == LEN_LO)) len_d = {len_q[LEN_W-1:BYTE_W], in_data};
            if (packAccept && packLast) wordCnt_d = wordCnt_q + LEN_W'(1);
        end
    end

    // Datapath and output registers; reset drops any pending write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q      <= '0;
            wordCnt_q  <= '0;
            xor_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            len_q      <= len_d;
            wordCnt_q  <= wordCnt_d;
            xor_q      <= xor_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cpu_rst  = cpu_rst_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
// Self-checking bench for imem_loader: memory writes are predicted into a
// scoreboard queue and popped by a monitor whenever wr_en is seen; status
// outputs are compared directly after each frame.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_rst;
    logic              done;
    logic              error;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t        expQ[$];
    logic [7:0] frame[$];
    int         total = 0;
    int         bad   = 0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpectedWrite: got addr 0x%0h data 0x%0h expected no write",
                         wr_addr, wr_data);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("wrAddr", 32'(wr_addr), 32'(e.addr));
                checkOutput("wrData", wr_data, e.data);
            end
        end
    end

    // Sends one byte after 'gap' idle cycles; returns 1 time unit after the
    // edge that transferred it.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        bit accepted;
        int waitCnt;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        accepted = 1'b0;
        waitCnt  = 0;
        while (!accepted && waitCnt < 100) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            waitCnt++;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL byteTimeout: got in_ready 0 for 100 cycles expected 1");
        end
    endtask

    task automatic sendFrame(input int maxGap);
        foreach (frame[i]) begin
            applyStimulus(frame[i], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstInReady", 32'(in_ready), 0);
        checkOutput("rstWrEn",    32'(wr_en),    0);
        checkOutput("rstWrAddr",  32'(wr_addr),  0);
        checkOutput("rstWrData",  wr_data,       0);
        checkOutput("rstCpuRst",  32'(cpu_rst),  1);
        checkOutput("rstDone",    32'(done),     0);
        checkOutput("rstError",   32'(error),    0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("idleInReady", 32'(in_ready), 0);

        // Single word frame.
        expQ.push_back('{addr: 8'h00, data: 32'h2008_0005});
        pulseStart();
        checkOutput("startInReady", 32'(in_ready), 1);
        frame = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05};
        sendFrame(0);
        checkOutput("wrEnNextCycle", 32'(wr_en), 1);
        checkOutput("cpuRstDuringLoad", 32'(cpu_rst), 1);
        applyStimulus(8'h2C, 0);
        checkOutput("singleDone",    32'(done),     1);
        checkOutput("singleError",   32'(error),    0);
        checkOutput("singleCpuRst",  32'(cpu_rst),  0);
        checkOutput("singleInReady", 32'(in_ready), 0);

        // Restart from DONE, then a zero-length image.
        pulseStart();
        checkOutput("restartCpuRst",  32'(cpu_rst),  1);
        checkOutput("restartDone",    32'(done),     0);
        checkOutput("restartInReady", 32'(in_ready), 1);
        frame = {8'h00, 8'h00, 8'h00};
        sendFrame(0);
        checkOutput("zeroDone",   32'(done),    1);
        checkOutput("zeroCpuRst", 32'(cpu_rst), 0);

        // Three words with random stalls.
        expQ.push_back('{addr: 8'h00, data: 32'h0000_0013});
        expQ.push_back('{addr: 8'h01, data: 32'h0010_0093});
        expQ.push_back('{addr: 8'h02, data: 32'hFFF0_0113});
        pulseStart();
        frame = {8'h00, 8'h03,
                 8'h00, 8'h00, 8'h00, 8'h13,
                 8'h00, 8'h10, 8'h00, 8'h93,
                 8'hFF, 8'hF0, 8'h01, 8'h13,
                 8'h8E};
        sendFrame(3);
        checkOutput("threeDone",   32'(done),    1);
        checkOutput("threeCpuRst", 32'(cpu_rst), 0);
        checkOutput("threeWrAddr", 32'(wr_addr), 3);
        checkOutput("threeAllWritten", 32'(expQ.size()), 0);

        // Bad checksum.
        expQ.push_back('{addr: 8'h00, data: 32'h2008_0005});
        pulseStart();
        frame = {8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
        sendFrame(0);
        checkOutput("badCsumError",   32'(error),    1);
        checkOutput("badCsumDone",    32'(done),     0);
        checkOutput("badCsumCpuRst",  32'(cpu_rst),  1);
        checkOutput("badCsumInReady", 32'(in_ready), 0);

        // Length overflow: 257 words into a 256-word memory.
        pulseStart();
        frame = {8'h01, 8'h01};
        sendFrame(0);
        checkOutput("ovfError",   32'(error),    1);
        checkOutput("ovfInReady", 32'(in_ready), 0);
        checkOutput("ovfCpuRst",  32'(cpu_rst),  1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("ovfStillError", 32'(error), 1);

        // Exactly full memory is accepted; abort it with reset mid-word.
        pulseStart();
        frame = {8'h01, 8'h00};
        sendFrame(0);
        checkOutput("fullLenError",   32'(error),    0);
        checkOutput("fullLenInReady", 32'(in_ready), 1);
        expQ.push_back('{addr: 8'h00, data: 32'h1122_3344});
        frame = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        sendFrame(0);
        checkOutput("preRstWrAddr", 32'(wr_addr), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstInReady", 32'(in_ready), 0);
        checkOutput("midRstWrEn",    32'(wr_en),    0);
        checkOutput("midRstWrAddr",  32'(wr_addr),  0);
        checkOutput("midRstWrData",  wr_data,       0);
        checkOutput("midRstCpuRst",  32'(cpu_rst),  1);
        checkOutput("midRstDone",    32'(done),     0);
        checkOutput("midRstError",   32'(error),    0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh load after reset starts at address 0.
        expQ.push_back('{addr: 8'h00, data: 32'hDEAD_BEEF});
        pulseStart();
        frame = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
        sendFrame(0);
        checkOutput("reloadDone",   32'(done),    1);
        checkOutput("reloadCpuRst", 32'(cpu_rst), 0);

        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
